rx_align_ctrl: RTL and testbench



---
 rtl/rx_align_pkg.sv | 13 +
 rtl/rx_pattern_check.sv | 46 ++++
 rtl/rx_align_ctrl.sv | 147 ++++++++++++++
 tb/tb_rx_align_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rx_align_pkg.sv
// rx_align_pkg: shared state encoding, tap width and word rotation helper for lane alignment
package rx_align_pkg;
  localparam int TAP_W = 9;
  typedef enum logic [3:0] {
    S_IDLE, S_VTC_OFF, S_LOAD, S_SETTLE, S_CHECK, S_EVAL,
    S_CENTER, S_CSETTLE, S_SLIP, S_LOCKED, S_FAIL
  } state_t;
  function automatic logic [7:0] rotl8(input logic [7:0] data, input logic [2:0] r);
    logic [15:0] t;
    t = {data, data} << r;
    return t[15:8];
  endfunction
endpackage

// File: rtl/rx_pattern_check.sv
// rx_pattern_check: scores one tap (first word must be a training rotation, all words equal) and reports the live rotation
module rx_pattern_check
  import rx_align_pkg::*;
#(
  parameter int         CHECK_WORDS = 64,
  parameter logic [7:0] TRAIN_PAT   = 8'hF0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_word,
  input  logic       i_clear,
  input  logic       i_enable,
  output logic       o_pass,
  output logic       o_done,
  output logic [2:0] o_rot
);
  logic [15:0] r_cnt;
  logic [7:0]  r_ref;
  logic        r_ok;
  logic        w_hit;
  always_comb begin
    w_hit = 1'b0;
    o_rot = '0;
    for (int i = 0; i < 8; i++)
      if (rotl8(i_word, 3'(i)) == TRAIN_PAT) begin
        w_hit = 1'b1;
        o_rot = 3'(i);
      end
  end
  assign o_done = i_enable && r_cnt == 16'(CHECK_WORDS - 1);
  assign o_pass = r_ok;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_ref <= '0;
      r_ok  <= 1'b0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_ok  <= 1'b0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 16'd1;
      r_ref <= (r_cnt == '0) ? i_word : r_ref;
      r_ok  <= (r_cnt == '0) ? w_hit : r_ok && i_word == r_ref;
    end
  end
endmodule

// File: rtl/rx_align_ctrl.sv
// rx_align_ctrl: sweeps IDELAY taps, centres on the widest stable window, then word-aligns the lane
module rx_align_ctrl
  import rx_align_pkg::*;
#(
  parameter int         TAP_MAX     = 511,
  parameter int         TAP_STEP    = 8,
  parameter int         SETTLE_CYC  = 16,
  parameter int         CHECK_WORDS = 64,
  parameter int         MIN_WIN     = 3,
  parameter logic [7:0] TRAIN_PAT   = 8'hF0
) (
  input  logic             rx_clkdiv4,
  input  logic             rx_reset,
  input  logic             start,
  input  logic [7:0]       px_data,
  output logic [TAP_W-1:0] rx_cntval,
  output logic             rx_dlyload,
  output logic             rx_ready,
  output logic [7:0]       aligned_data,
  output logic             aligned_valid,
  output logic             locked,
  output logic             fail,
  output logic             busy,
  output logic [TAP_W-1:0] win_start,
  output logic [TAP_W-1:0] win_end,
  output logic [2:0]       slip
);
  state_t           r_state, w_next;
  logic [15:0]      r_cnt;
  logic [TAP_W-1:0] r_tap, r_rs, r_re, r_ws, r_we, r_cntval;
  logic [9:0]       r_rlen, r_blen;
  logic             r_open, r_ld, r_dlyload;
  logic [2:0]       r_slip;
  logic [7:0]       r_adata;
  logic             w_pass, w_chk_done, w_last, w_settled, w_slip_ok, w_close;
  logic [2:0]       w_rot;
  logic [9:0]       w_next_tap, w_sum, w_len, w_cl;
  logic [TAP_W-1:0] w_rs, w_cs, w_ce;
  rx_pattern_check #(.CHECK_WORDS(CHECK_WORDS), .TRAIN_PAT(TRAIN_PAT)) u_chk (
    .i_clk(rx_clkdiv4),
    .i_rst(rx_reset),
    .i_word(px_data),
    .i_clear(r_state != S_CHECK),
    .i_enable(r_state == S_CHECK),
    .o_pass(w_pass),
    .o_done(w_chk_done),
    .o_rot(w_rot)
  );
  assign w_next_tap = {1'b0, r_tap} + 10'(TAP_STEP);
  assign w_last     = w_next_tap > 10'(TAP_MAX);
  assign w_settled  = r_cnt == 16'(SETTLE_CYC - 1);
  assign w_slip_ok  = rotl8(px_data, w_rot) == TRAIN_PAT;
  assign w_sum      = {1'b0, r_ws} + {1'b0, r_we};
  assign w_rs       = r_open ? r_rs : r_tap;
  assign w_len      = r_open ? r_rlen + 10'd1 : 10'd1;
  assign w_cs       = w_pass ? w_rs : r_rs;
  assign w_ce       = w_pass ? r_tap : r_re;
  assign w_cl       = w_pass ? w_len : r_rlen;
  // a passing tap closes its run only when the sweep ends; a failing tap closes whatever is open
  assign w_close    = w_pass ? w_last : r_open;
  assign rx_cntval     = r_cntval;
  assign rx_dlyload    = r_dlyload;
  assign aligned_data  = r_adata;
  assign win_start     = r_ws;
  assign win_end       = r_we;
  assign slip          = r_slip;
  always_ff @(posedge rx_clkdiv4 or posedge rx_reset)
    if (rx_reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_VTC_OFF: w_next = w_settled ? S_LOAD : S_VTC_OFF;
      S_LOAD:    w_next = S_SETTLE;
      S_SETTLE:  w_next = w_settled ? S_CHECK : S_SETTLE;
      S_CHECK:   w_next = w_chk_done ? S_EVAL : S_CHECK;
      S_EVAL:    w_next = w_last ? S_CENTER : S_LOAD;
      S_CENTER:  w_next = (r_blen < 10'(MIN_WIN)) ? S_FAIL : S_CSETTLE;
      S_CSETTLE: w_next = w_settled ? S_SLIP : S_CSETTLE;
      S_SLIP:    w_next = w_slip_ok ? S_LOCKED : S_FAIL;
      default:   w_next = r_state;
    endcase
    if (start) w_next = S_VTC_OFF;
    rx_ready      = r_state inside {S_IDLE, S_LOCKED, S_FAIL};
    busy          = !(r_state inside {S_IDLE, S_LOCKED, S_FAIL});
    locked        = r_state == S_LOCKED;
    fail          = r_state == S_FAIL;
    aligned_valid = r_state == S_LOCKED;
  end
  // cntval is written one cycle ahead of the strobe so it is stable before, during and after it
  always_ff @(posedge rx_clkdiv4 or posedge rx_reset) begin
    if (rx_reset) begin
      r_cnt     <= '0;
      r_tap     <= '0;
      r_rs      <= '0;
      r_re      <= '0;
      r_ws      <= '0;
      r_we      <= '0;
      r_cntval  <= '0;
      r_rlen    <= '0;
      r_blen    <= '0;
      r_open    <= 1'b0;
      r_ld      <= 1'b0;
      r_dlyload <= 1'b0;
      r_slip    <= '0;
      r_adata   <= '0;
    end else begin
      r_cnt     <= (start || w_next != r_state) ? '0 : r_cnt + 16'd1;
      r_ld      <= 1'b0;
      r_dlyload <= r_ld;
      if (r_state == S_VTC_OFF) begin
        r_tap  <= '0;
        r_rs   <= '0;
        r_re   <= '0;
        r_ws   <= '0;
        r_we   <= '0;
        r_rlen <= '0;
        r_blen <= '0;
        r_open <= 1'b0;
      end
      if (w_next == S_LOAD) begin
        r_cntval <= (r_state == S_EVAL) ? 9'(w_next_tap) : '0;
        r_ld     <= 1'b1;
      end
      if (r_state == S_EVAL) begin
        r_open <= w_pass && !w_last;
        if (w_pass) begin
          r_rs   <= w_rs;
          r_re   <= r_tap;
          r_rlen <= w_len;
        end
        if (w_close && w_cl > r_blen) begin
          r_ws   <= w_cs;
          r_we   <= w_ce;
          r_blen <= w_cl;
        end
        if (!w_last) r_tap <= 9'(w_next_tap);
      end
      if (r_state == S_CENTER && w_next == S_CSETTLE) begin
        r_cntval <= 9'(w_sum >> 1);
        r_ld     <= 1'b1;
      end
      if (r_state == S_SLIP && w_next == S_LOCKED) r_slip <= w_rot;
      if (r_state == S_LOCKED) r_adata <= rotl8(px_data, r_slip);
    end
  end
endmodule

// File: tb/tb_rx_align_ctrl.sv
// tb_rx_align_ctrl: randomized lane model and window reference for rx_align_ctrl
module tb_rx_align_ctrl;
  localparam int TAP_MAX = 511;
  localparam int STEP    = 8;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] px = 8'h00;
  logic [8:0] cntval, wstart, wend;
  logic       dlyload, rdy, avalid, locked, fail, busy;
  logic [7:0] adata;
  logic [2:0] slip;
  int total = 0;
  int bad = 0;
  int lo1 = -1, hi1 = -2, lo2 = -1, hi2 = -2;
  bit lane_on = 1'b0;
  logic [7:0] lane_word = 8'h00;
  int tb_tap = 0;
  bit p_dly = 1'b0;
  int p_cnt = 0;
  rx_align_ctrl dut (
    .rx_clkdiv4(clk), .rx_reset(rst), .start(start), .px_data(px),
    .rx_cntval(cntval), .rx_dlyload(dlyload), .rx_ready(rdy),
    .aligned_data(adata), .aligned_valid(avalid), .locked(locked),
    .fail(fail), .busy(busy), .win_start(wstart), .win_end(wend), .slip(slip)
  );
  initial forever #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic bit in_win(input int t);
    return (t >= lo1 && t <= hi1) || (t >= lo2 && t <= hi2);
  endfunction
  function automatic int rotl(input int d, input int r);
    return ((d << r) | (d >> (8 - r))) & 255;
  endfunction
  always @(posedge clk) if (dlyload) tb_tap <= int'(cntval);
  initial forever begin
    @(negedge clk);
    if (lane_on) px = in_win(tb_tap) ? lane_word : 8'($urandom);
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (dlyload) begin
        chk("dly_while_ready", int'(rdy), 0);
        chk("dly_len", int'(p_dly), 0);
        chk("cnt_before_dly", int'(cntval), p_cnt);
      end
      if (p_dly) chk("cnt_after_dly", int'(cntval), p_cnt);
    end
    p_dly = dlyload;
    p_cnt = int'(cntval);
  end
  task automatic check_reset_vals(input string tag);
    chk({tag, "_cntval"}, int'(cntval), 0);
    chk({tag, "_dlyload"}, int'(dlyload), 0);
    chk({tag, "_ready"}, int'(rdy), 1);
    chk({tag, "_adata"}, int'(adata), 0);
    chk({tag, "_avalid"}, int'(avalid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_fail"}, int'(fail), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_wstart"}, int'(wstart), 0);
    chk({tag, "_wend"}, int'(wend), 0);
    chk({tag, "_slip"}, int'(slip), 0);
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_ready", int'(rdy), 0);
    chk("start_locked", int'(locked), 0);
    chk("start_fail", int'(fail), 0);
    chk("start_avalid", int'(avalid), 0);
  endtask
  task automatic wait_done();
    int n = 0;
    while (!(locked || fail) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("train_timeout", int'(n < 8000), 1);
  endtask
  task automatic run_scn(input int a1, input int b1, input int a2, input int b2,
                         input int rot, input int restart_at);
    int r0, bs, be, bl, cs, cl, last, n;
    bit exp_lock;
    lo1 = a1; hi1 = b1; lo2 = a2; hi2 = b2;
    r0 = (rot < 0) ? int'($urandom_range(0, 7)) : rot;
    lane_word = 8'(rotl(8'hF0, (8 - r0) % 8));
    bs = 0; be = 0; bl = 0; cs = 0; cl = 0; last = 0;
    for (int t = 0; t <= TAP_MAX + STEP; t += STEP) begin
      if (t <= TAP_MAX) last = t;
      if (t <= TAP_MAX && in_win(t)) begin
        if (cl == 0) cs = t;
        cl++;
      end else begin
        if (cl > bl) begin
          bs = cs; be = t - STEP; bl = cl;
        end
        cl = 0;
      end
    end
    exp_lock = bl >= 3;
    lane_on = 1'b1;
    pulse_start();
    if (restart_at > 0) begin
      repeat (restart_at) @(negedge clk);
      pulse_start();
      n = 0;
      while (!dlyload && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("restart_load_seen", int'(n < 200), 1);
      chk("restart_tap", int'(cntval), 0);
    end
    wait_done();
    chk("locked", int'(locked), int'(exp_lock));
    chk("fail", int'(fail), int'(!exp_lock));
    chk("busy_done", int'(busy), 0);
    chk("ready_done", int'(rdy), 1);
    chk("win_start", int'(wstart), bs);
    chk("win_end", int'(wend), be);
    if (exp_lock) begin
      chk("center", int'(cntval), (bs + be) / 2);
      chk("slip", int'(slip), r0);
      lane_on = 1'b0;
      for (int i = 0; i < 6; i++) begin
        px = 8'($urandom);
        @(negedge clk);
        chk("aligned_data", int'(adata), rotl(int'(px), r0));
        chk("aligned_valid", int'(avalid), 1);
      end
    end else begin
      chk("fail_cntval", int'(cntval), last);
      chk("fail_avalid", int'(avalid), 0);
    end
  endtask
  initial begin
    int a, b, c, d;
    #12;
    check_reset_vals("rst0");
    @(negedge clk);
    rst = 1'b0;
    run_scn(120, 280, -1, -2, 3, 0);
    chk("spec_adata", int'(adata == 8'hF0 || px != 8'h1E), 1);
    run_scn(40, 64, 300, 324, -1, 0);
    lane_on = 1'b1;
    pulse_start();
    repeat (120) @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_cntval", int'(cntval), 8);
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    run_scn(496, 511, -1, -2, -1, 0);
    run_scn(-1, -2, -1, -2, -1, 0);
    a = $urandom_range(0, 300);
    run_scn(a, a + int'($urandom_range(16, 150)), -1, -2, -1, 300);
    a = $urandom_range(0, 150);
    b = a + int'($urandom_range(0, 80));
    c = b + int'($urandom_range(10, 100));
    d = c + int'($urandom_range(0, 120));
    run_scn(a, b, c, d, -1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
